// File: rtl/count_sequence_checker.sv
// Monitors a free-running up-counter: checks each valid sample is prev+1 (mod 2^WIDTH),
// tracks lock, and reports error/wrap pulses with saturating tallies.
module count_sequence_checker #(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned LOCK_CNT = 2,
   parameter int unsigned TALLY_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_in,
   input  logic [WIDTH-1:0]   count_in,
   output logic               locked,
   output logic               err_pulse,
   output logic               wrap_pulse,
   output logic [TALLY_W-1:0] err_count,
   output logic [TALLY_W-1:0] wrap_count
);

   localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
   localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   prev_q, prev_d;
   logic [RUN_W-1:0]   good_run_q, good_run_d;
   logic               locked_q, locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic               wrap_pulse_q, wrap_pulse_d;
   logic [TALLY_W-1:0] err_count_q, err_count_d;
   logic [TALLY_W-1:0] wrap_count_q, wrap_count_d;

   logic [WIDTH-1:0]   expected_c;
   logic               match_c;
   logic [RUN_W-1:0]   run_inc_c;

   // Truncating add makes max -> 0 a legal step
   assign expected_c = prev_q + WIDTH'(1);
   assign match_c    = (count_in == expected_c);
   assign run_inc_c  = good_run_q + RUN_W'(1);

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      good_run_d   = good_run_q;
      err_pulse_d  = 1'b0;
      wrap_pulse_d = 1'b0;
      err_count_d  = err_count_q;
      wrap_count_d = wrap_count_q;

      if (valid_in) begin
         prev_d = count_in;
         unique case (state_q)
            ST_IDLE: begin
               good_run_d = '0;
               state_d    = ST_SEARCH;
            end
            ST_SEARCH: begin
               if (match_c) begin
                  good_run_d = run_inc_c;
                  if (run_inc_c == RUN_LOCK) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  good_run_d = '0;
               end
            end
            ST_LOCKED: begin
               if (match_c) begin
                  if (count_in == '0) begin
                     wrap_pulse_d = 1'b1;
                     if (wrap_count_q != '1) begin
                        wrap_count_d = wrap_count_q + TALLY_W'(1);
                     end
                  end
               end else begin
                  err_pulse_d = 1'b1;
                  good_run_d  = '0;
                  state_d     = ST_SEARCH;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + TALLY_W'(1);
                  end
               end
            end
            default: begin
               good_run_d = '0;
               state_d    = ST_IDLE;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers; synchronous reset wins over valid_in
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         prev_q       <= '0;
         good_run_q   <= '0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         wrap_pulse_q <= 1'b0;
         err_count_q  <= '0;
         wrap_count_q <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         good_run_q   <= good_run_d;
         locked_q     <= locked_d;
         err_pulse_q  <= err_pulse_d;
         wrap_pulse_q <= wrap_pulse_d;
         err_count_q  <= err_count_d;
         wrap_count_q <= wrap_count_d;
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign wrap_pulse = wrap_pulse_q;
   assign err_count  = err_count_q;
   assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed plus randomized bench for count_sequence_checker; two instances (TALLY_W=8 and 2)
// share one stimulus and are compared against a run-length reference model.
module tb_count_sequence_checker;

   localparam int unsigned W    = 3;
   localparam int unsigned LOCK = 2;
   localparam int unsigned MOD  = 1 << W;

   logic         clk;
   logic         rst;
   logic         valid_in;
   logic [W-1:0] count_in;
   logic         locked, err_pulse, wrap_pulse;
   logic [7:0]   err_count, wrap_count;
   logic         locked2, err_pulse2, wrap_pulse2;
   logic [1:0]   err_count2, wrap_count2;

   count_sequence_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .TALLY_W(8)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in),
      .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
      .err_count(err_count), .wrap_count(wrap_count));

   count_sequence_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .TALLY_W(2)) dut2 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in),
      .locked(locked2), .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2),
      .err_count(err_count2), .wrap_count(wrap_count2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference: locked means at least LOCK consecutive good steps since the last break
   bit       m_have;
   int       m_prev;
   int       m_run;
   bit       m_ep, m_wp;
   int       m_nerr, m_nwrap;
   int       last;

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   task automatic model_step(input bit r, input bit v, input int c);
      bit was_locked;
      m_ep = 1'b0;
      m_wp = 1'b0;
      if (r) begin
         m_have = 1'b0; m_prev = 0; m_run = 0; m_nerr = 0; m_nwrap = 0;
      end else if (v) begin
         if (!m_have) begin
            m_have = 1'b1;
            m_run  = 0;
         end else begin
            was_locked = (m_run >= LOCK);
            if (c == (m_prev + 1) % MOD) begin
               if (m_run < LOCK) m_run++;
               if (was_locked && c == 0) begin
                  m_wp = 1'b1;
                  m_nwrap++;
               end
            end else begin
               m_run = 0;
               if (was_locked) begin
                  m_ep = 1'b1;
                  m_nerr++;
               end
            end
         end
         m_prev = c;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit v, input int c);
      rst      = r;
      valid_in = v;
      count_in = W'(c);
      if (v && !r) last = c;
      @(posedge clk);
      model_step(r, v, c);
      #1;
      chk("locked",      32'(locked),      32'(m_run >= LOCK));
      chk("err_pulse",   32'(err_pulse),   32'(m_ep));
      chk("wrap_pulse",  32'(wrap_pulse),  32'(m_wp));
      chk("err_count",   32'(err_count),   32'(sat(m_nerr, 255)));
      chk("wrap_count",  32'(wrap_count),  32'(sat(m_nwrap, 255)));
      chk("err_pulse2",  32'(err_pulse2),  32'(m_ep));
      chk("err_count2",  32'(err_count2),  32'(sat(m_nerr, 3)));
      chk("wrap_count2", 32'(wrap_count2), 32'(sat(m_nwrap, 3)));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0);
   endtask

   initial begin
      int ep_seen;
      int c;
      rst = 1'b1; valid_in = 1'b0; count_in = '0;
      last = 0;
      m_have = 1'b0; m_prev = 0; m_run = 0; m_nerr = 0; m_nwrap = 0; m_ep = 0; m_wp = 0;

      // 1: reset, then 0..7,0,1
      do_reset(2);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      cyc(0, 1, 0);
      cyc(0, 1, 1);
      chk("t1_not_yet_locked", 32'(locked), 32'd0);
      cyc(0, 1, 2);
      chk("t1_locked_after_2", 32'(locked), 32'd1);
      for (int i = 3; i < 8; i++) cyc(0, 1, i);
      cyc(0, 1, 0);
      chk("t1_wrap_pulse", 32'(wrap_pulse), 32'd1);
      cyc(0, 1, 1);
      chk("t1_wrap_count", 32'(wrap_count), 32'd1);
      chk("t1_err_count", 32'(err_count), 32'd0);

      // 2: lock, inject 3,4,6,7, relock
      do_reset(1);
      cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 3); cyc(0, 1, 4);
      cyc(0, 1, 6);
      chk("t2_err_pulse", 32'(err_pulse), 32'd1);
      chk("t2_unlocked", 32'(locked), 32'd0);
      cyc(0, 1, 7);
      chk("t2_err_pulse_gone", 32'(err_pulse), 32'd0);
      cyc(0, 1, 0);
      chk("t2_relocked", 32'(locked), 32'd1);
      chk("t2_err_count", 32'(err_count), 32'd1);

      // 3: valid gaps with junk on count_in
      cyc(0, 1, 1); cyc(0, 1, 2);
      for (int i = 0; i < 5; i++) cyc(0, 0, int'($urandom_range(0, MOD - 1)));
      cyc(0, 1, 3);
      chk("t3_still_locked", 32'(locked), 32'd1);
      chk("t3_err_count", 32'(err_count), 32'd1);

      // 4: repeated value is a mismatch
      cyc(0, 1, 4); cyc(0, 1, 5); cyc(0, 1, 5);
      chk("t4_err_pulse", 32'(err_pulse), 32'd1);
      chk("t4_err_count", 32'(err_count), 32'd2);

      // 5: five locked mismatches saturate the 2-bit tally
      do_reset(1);
      c = 0;
      ep_seen = 0;
      cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 2);
      c = 2;
      for (int k = 0; k < 5; k++) begin
         c = (c + 3) % MOD;
         cyc(0, 1, c);
         if (err_pulse2) ep_seen++;
         c = (c + 1) % MOD; cyc(0, 1, c);
         c = (c + 1) % MOD; cyc(0, 1, c);
      end
      chk("t5_pulses", 32'(ep_seen), 32'd5);
      chk("t5_sat_count", 32'(err_count2), 32'd3);
      chk("t5_wide_count", 32'(err_count), 32'd5);

      // 6: two wraps, then mid-stream reset
      do_reset(1);
      for (int i = 0; i < 18; i++) cyc(0, 1, i % MOD);
      chk("t6_wrap_count", 32'(wrap_count), 32'd2);
      do_reset(1);
      chk("t6_rst_locked", 32'(locked), 32'd0);
      chk("t6_rst_wrap", 32'(wrap_count), 32'd0);
      cyc(0, 1, 5);
      cyc(0, 1, 2);
      chk("t6_no_err_in_search", 32'(err_pulse), 32'd0);

      // Randomized stream, mostly in sequence
      for (int i = 0; i < 600; i++) begin
         bit r, v;
         r = ($urandom_range(0, 99) == 0);
         v = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 9) < 8) c = (last + 1) % MOD;
         else c = int'($urandom_range(0, MOD - 1));
         cyc(r, v, c);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
